// File: rtl/pc_sequencer_if.sv
// Request/response bundle between the decode/control logic and the
// program-counter sequencer. The master drives the requests and the slave
// (the sequencer) returns the fetch address and the RAS status.
interface pc_sequencer_if #(
    parameter int PC_WIDTH  = 8,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic                stall;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_offset;
    logic                jump_valid;
    logic                call;
    logic                ret;
    logic [PC_WIDTH-1:0] jump_target;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next;
    logic [CNT_W-1:0]    ras_count;
    logic                ras_overflow;
    logic                ras_underflow;

    modport master (
        output stall, branch_taken, branch_offset, jump_valid, call, ret, jump_target,
        input  pc, pc_next, ras_count, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump_valid, call, ret, jump_target,
        output pc, pc_next, ras_count, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Parametrised fetch program counter with stall, signed relative branches,
// absolute jumps and call/return through a small circular return-address
// stack. pc is registered; pc_next is the value it takes at the next edge.
module pc_sequencer #(
    parameter int                     PC_WIDTH  = 8,
    parameter int                     RAS_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    pc_sequencer_if.slave       io_bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0]    r_tp;
    logic [CNT_W-1:0]    r_count;
    logic                r_overflow;
    logic                r_underflow;

    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic                w_ras_empty;
    logic                w_ras_full;
    logic                w_push;
    logic                w_pop;
    logic                w_overflow;
    logic                w_underflow;

    assign w_pc_inc    = r_pc + PC_WIDTH'(1);
    assign w_ras_empty = (r_count == {CNT_W{1'b0}});
    assign w_ras_full  = (r_count == CNT_FULL);

    // Next-PC and RAS action selection, highest priority request wins.
    always_comb begin
        w_pc_next   = w_pc_inc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_overflow  = 1'b0;
        w_underflow = 1'b0;
        if (io_bus.stall) begin
            w_pc_next = r_pc;
        end else if (io_bus.ret) begin
            if (!w_ras_empty) begin
                w_pc_next = r_ras[r_tp];
                w_pop     = 1'b1;
            end else begin
                w_pc_next   = w_pc_inc;
                w_underflow = 1'b1;
            end
        end else if (io_bus.call) begin
            w_pc_next  = io_bus.jump_target;
            w_push     = 1'b1;
            w_overflow = w_ras_full;
        end else if (io_bus.jump_valid) begin
            w_pc_next = io_bus.jump_target;
        end else if (io_bus.branch_taken) begin
            // Unsigned add wraps identically to a signed offset in two's complement.
            w_pc_next = w_pc_inc + io_bus.branch_offset;
        end else begin
            w_pc_next = w_pc_inc;
        end
    end

    // PC register and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_overflow  <= w_overflow;
            r_underflow <= w_underflow;
        end
    end

    // Return-address stack: circular buffer, full pushes overwrite the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tp    <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_ras[i] <= {PC_WIDTH{1'b0}};
            end
        end else if (w_push) begin
            r_ras[r_tp + PTR_W'(1)] <= w_pc_inc;
            r_tp                    <= r_tp + PTR_W'(1);
            if (!w_ras_full) begin
                r_count <= r_count + CNT_W'(1);
            end else begin
                r_count <= r_count;
            end
        end else if (w_pop) begin
            r_tp    <= r_tp - PTR_W'(1);
            r_count <= r_count - CNT_W'(1);
        end else begin
            r_tp    <= r_tp;
            r_count <= r_count;
        end
    end

    assign io_bus.pc            = r_pc;
    assign io_bus.pc_next       = w_pc_next;
    assign io_bus.ras_count     = r_count;
    assign io_bus.ras_overflow  = r_overflow;
    assign io_bus.ras_underflow = r_underflow;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter unit: the next generation of the team's 8-bit fetch PC.
- Adds a configurable width, an active-low asynchronous reset with a programmable reset vector, and a stall input.
- Adds signed relative branches, absolute jumps, and call/return backed by a small circular return-address stack (RAS).
- Sits between the decode/control logic and instruction memory; drives the fetch address every cycle.

Parameters:
- PC_WIDTH, 8: width of PC, targets and offsets.
- RAS_DEPTH, 4: number of return-address entries (power of two, >= 2).
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC and RAS this cycle.
- branch_taken  input  1  relative branch request.
- branch_offset  input  PC_WIDTH  signed two's-complement offset added to pc+1.
- jump_valid  input  1  absolute jump request.
- call  input  1  push pc+1 onto the RAS and go to jump_target.
- ret  input  1  pop the RAS and go to the popped address.
- jump_target  input  PC_WIDTH  absolute target for jump_valid and call.
- pc  output  PC_WIDTH  current fetch address (registered).
- pc_next  output  PC_WIDTH  combinational value pc will take at the next edge.
- ras_count  output  clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_overflow  output  1  registered one-cycle pulse: a call was made while the RAS was full.
- ras_underflow  output  1  registered one-cycle pulse: a ret was made while the RAS was empty.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately regardless of clk):
  - pc=RESET_PC, ras_count=0, stack pointer=0.
  - ras_overflow=0, ras_underflow=0.
  - RAS contents are don't-care.
  - Deassertion is sampled synchronously: the first update happens at the first rising edge with rst_n=1.
- Next-PC selection, priority highest first, evaluated each cycle:
  1. stall: pc_next=pc. RAS unchanged, both error pulses 0. All other requests are ignored.
  2. ret:
     - RAS non-empty: pc_next=top entry; pop (ras_count-1).
     - RAS empty: pc_next=pc+1, ras_underflow=1 next cycle, ras_count stays 0.
  3. call:
     - pc_next=jump_target; push pc+1.
     - RAS full: overwrite the oldest entry (circular), ras_count stays RAS_DEPTH, ras_overflow=1 next cycle.
  4. jump_valid: pc_next=jump_target.
  5. branch_taken: pc_next=pc+1+branch_offset.
  6. Otherwise: pc_next=pc+1.
- Simultaneous requests: only the highest-priority request acts; lower ones are dropped with no side effects. For example, call+ret performs the ret only.
- Arithmetic:
  - All sums are PC_WIDTH bits and wrap modulo 2^PC_WIDTH; there is no overflow flag.
  - branch_offset is sign-interpreted: 0xFF means -1, so a branch with offset 0xFF re-fetches the current pc.
  - The pushed return address is pc+1, wrapped.
- RAS:
  - Circular buffer with top-of-stack pointer tp.
  - Push writes entry[tp+1] and increments tp. Pop reads entry[tp] and decrements tp.
  - Pointer arithmetic is modulo RAS_DEPTH.
  - After an overflow, a full depth of pops returns the most recent RAS_DEPTH pushes in LIFO order.
- Latency:
  - pc updates one cycle after a request is sampled.
  - pc_next reflects the current inputs combinationally.
  - Error pulses are registered, so they are high for exactly the cycle after the offending edge.
- Reset mid-operation: pc returns to RESET_PC and the RAS is emptied immediately; any pending request is lost.

Test Plan:
1. Reset/increment: RESET_PC=0x10, release rst_n, 3 idle edges -> pc=0x11, 0x12, 0x13. Assert rst_n=0 between edges -> pc=0x10 at once, without a clock edge.
2. Branch and wrap:
   - pc=0x20, branch_taken with offset 0xFE (-2) -> pc=0x1F.
   - pc=0xFF, idle edge -> pc=0x00.
   - pc=0xF0, offset 0x20 -> pc=0x11.
3. Call/ret:
   - pc=0x05, call with target 0x40 -> pc=0x40, ras_count=1.
   - 2 idle edges -> pc=0x42.
   - ret -> pc=0x06, ras_count=0.
4. Overflow/underflow, RAS_DEPTH=4:
   - 5 nested calls from pcs 0x00, 0x10, 0x20, 0x30, 0x40, each with target (pc+0x10) -> ras_overflow pulses once, after the 5th call; ras_count=4.
   - 4 rets -> pc=0x41, 0x31, 0x21, 0x11.
   - 5th ret -> pc=pc+1, ras_underflow pulses for one cycle.
5. Priority/stall:
   - stall with call+jump+branch asserted -> pc and ras_count unchanged, no pulses.
   - call+ret together with RAS=[0x33] -> pc=0x33, ras_count=0.
   - jump_valid+branch_taken together -> pc=jump_target.
6. Reset during RAS use: 2 calls, then rst_n low -> pc=RESET_PC, ras_count=0. The next ret underflows.
